// File: rtl/sc_boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encodings and frame field widths.
package sc_boot_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/sc_boot_loader_word_packer.sv
// Shifts bytes big-endian into a 32-bit word; pulses word_valid the cycle after the 4th byte.
module sc_word_packer
  import sc_boot_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [31:0]       o_word,
  output logic              o_word_valid
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_vld;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_word <= 32'd0;
      r_idx  <= 2'd0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= i_push && (r_idx == 2'd3);
      if (i_push) begin
        r_word <= {r_word[23:0], i_byte};
        r_idx  <= r_idx + 2'd1;
      end
    end
  end

  // The word register only moves on a push, so it is stable during the strobe cycle.
  assign o_word       = r_word;
  assign o_word_valid = r_vld;

endmodule

// File: rtl/sc_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory and
// releases the CPU from reset only once the whole image has arrived intact.
module sc_boot_loader
  import sc_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
)(
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_in_valid,
  input  logic [BYTE_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_im_we,
  output logic [31:0]       o_im_addr,
  output logic [31:0]       o_im_wdata,
  output logic              o_cpu_clrn,
  output logic              o_done,
  output logic              o_error
);

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_word_cnt;
  logic [1:0]         r_byte_idx;
  logic [BYTE_W-1:0]  r_csum;
  logic [31:0]        r_addr;
  logic               w_xfer;
  logic               w_push;
  logic               w_word_vld;
  logic [31:0]        w_word;
  logic [LEN_W-1:0]   w_len_new;

  assign o_in_ready = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                      (r_state == ST_DATA)   || (r_state == ST_CSUM);
  assign w_xfer     = i_in_valid && o_in_ready;
  assign w_push     = w_xfer && (r_state == ST_DATA);
  assign w_len_new  = {r_len[15:8], i_in_data};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LEN_HI: if (w_xfer) w_state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (w_xfer) begin
        if (w_len_new == '0)                         w_state_nxt = ST_CSUM;
        else if ({16'd0, w_len_new} > 32'(MAX_WORDS)) w_state_nxt = ST_ERR;
        else                                         w_state_nxt = ST_DATA;
      end
      ST_DATA: if (w_xfer && (r_byte_idx == 2'd3) && (r_word_cnt + 16'd1 == r_len))
        w_state_nxt = ST_CSUM;
      ST_CSUM: if (w_xfer) w_state_nxt = (i_in_data == r_csum) ? ST_RUN : ST_ERR;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state    <= ST_LEN_HI;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= 2'd0;
      r_csum     <= '0;
      r_addr     <= BASE_ADDR;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && (r_state != ST_CSUM)) r_csum <= r_csum ^ i_in_data;
      if (w_xfer && (r_state == ST_LEN_HI)) r_len[15:8] <= i_in_data;
      if (w_xfer && (r_state == ST_LEN_LO)) r_len[7:0]  <= i_in_data;
      if (w_push) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) r_word_cnt <= r_word_cnt + 16'd1;
      end
      // Address advances after each strobe, so the next word sees BASE_ADDR + 4*k.
      if (w_word_vld) r_addr <= r_addr + 32'd4;
    end
  end

  sc_word_packer u_packer (
    .i_clk        (i_clk),
    .i_clr        (i_clr),
    .i_push       (w_push),
    .i_byte       (i_in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_vld)
  );

  assign o_im_we    = w_word_vld;
  assign o_im_addr  = r_addr;
  assign o_im_wdata = w_word;
  assign o_cpu_clrn = (r_state == ST_RUN);
  assign o_done     = (r_state == ST_RUN);
  assign o_error    = (r_state == ST_ERR);

endmodule

// File: tb/tb_sc_boot_loader.sv
// Scoreboard bench: expected instmem writes are queued as frames are driven and popped on im_we.
module tb_sc_boot_loader;

  logic        i_clk = 1'b0;
  logic        i_clr = 1'b1;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_in_data = 8'd0;
  logic        o_in_ready, o_im_we, o_cpu_clrn, o_done, o_error;
  logic [31:0] o_im_addr, o_im_wdata;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] img[0:1] = '{32'h3C011001, 32'h20210005};

  always #5 i_clk = ~i_clk;

  sc_boot_loader dut (
    .i_clk      (i_clk),
    .i_clr      (i_clr),
    .i_in_valid (i_in_valid),
    .i_in_data  (i_in_data),
    .o_in_ready (o_in_ready),
    .o_im_we    (o_im_we),
    .o_im_addr  (o_im_addr),
    .o_im_wdata (o_im_wdata),
    .o_cpu_clrn (o_cpu_clrn),
    .o_done     (o_done),
    .o_error    (o_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_im_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_we", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("we_addr", o_im_addr, e[63:32]);
        chk("we_data", o_im_wdata, e[31:0]);
      end
    end
  end

  task automatic do_reset(input int cycles);
    i_in_valid = 1'b0;
    i_clr = 1'b1;
    repeat (cycles) @(posedge i_clk);
    #1 i_clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) @(posedge i_clk);
      #1;
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    @(posedge i_clk);
    #1 i_in_valid = 1'b0;
    i_in_data = $urandom_range(255, 0);
  endtask

  // Sends the two-word image; stop_after limits the data bytes driven (-1 = whole frame).
  task automatic send_frame(input bit gaps, input bit bad_csum, input int stop_after);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00 ^ 8'h02;
    send_byte(8'h00, gaps);
    send_byte(8'h02, gaps);
    for (int k = 0; k < 8; k++) begin
      if (stop_after >= 0 && k >= stop_after) return;
      b = img[k/4][31 - 8*(k%4) -: 8];
      cs ^= b;
      if (k % 4 == 3) sb_q.push_back({32'(4 * (k/4)), img[k/4]});
      send_byte(b, gaps);
    end
    chk("done_before_csum", {31'd0, o_done}, 32'd0);
    send_byte(bad_csum ? 8'h00 : cs, gaps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset(2);
    @(negedge i_clk);
    chk("rst_ready", {31'd0, o_in_ready}, 32'd1);
    chk("rst_clrn",  {31'd0, o_cpu_clrn}, 32'd0);
    chk("rst_done",  {31'd0, o_done},     32'd0);
    chk("rst_error", {31'd0, o_error},    32'd0);
    chk("rst_we",    {31'd0, o_im_we},    32'd0);
    chk("rst_addr",  o_im_addr,  32'h0);
    chk("rst_wdata", o_im_wdata, 32'h0);

    // Good frame, back-to-back
    @(posedge i_clk); #1;
    send_frame(1'b0, 1'b0, -1);
    chk("t2_done", {31'd0, o_done}, 32'd1);
    chk("t2_clrn", {31'd0, o_cpu_clrn}, 32'd1);
    chk("t2_ready", {31'd0, o_in_ready}, 32'd0);
    repeat (3) @(posedge i_clk);
    #1 chk("t2_done_hold", {31'd0, o_done}, 32'd1);
    chk("t2_sb_empty", sb_q.size(), 0);

    // Bad checksum
    do_reset(1);
    send_frame(1'b0, 1'b1, -1);
    chk("t3_error", {31'd0, o_error}, 32'd1);
    chk("t3_done",  {31'd0, o_done}, 32'd0);
    chk("t3_clrn",  {31'd0, o_cpu_clrn}, 32'd0);
    chk("t3_ready", {31'd0, o_in_ready}, 32'd0);
    repeat (2) @(negedge i_clk);
    chk("t3_sb_empty", sb_q.size(), 0);

    // Empty image
    do_reset(1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("t4_csum_ready", {31'd0, o_in_ready}, 32'd1);
    send_byte(8'h00, 1'b0);
    chk("t4_done", {31'd0, o_done}, 32'd1);
    chk("t4_error", {31'd0, o_error}, 32'd0);

    // Oversized length: 1025 words
    do_reset(1);
    send_byte(8'h04, 1'b0);
    chk("t4b_not_yet", {31'd0, o_error}, 32'd0);
    send_byte(8'h01, 1'b0);
    chk("t4b_error", {31'd0, o_error}, 32'd1);
    chk("t4b_ready", {31'd0, o_in_ready}, 32'd0);
    chk("t4b_done",  {31'd0, o_done}, 32'd0);

    // Random valid gaps
    do_reset(1);
    send_frame(1'b1, 1'b0, -1);
    chk("t5_done", {31'd0, o_done}, 32'd1);
    repeat (2) @(negedge i_clk);
    chk("t5_sb_empty", sb_q.size(), 0);

    // Abort after 5 data bytes, then resend
    do_reset(1);
    send_frame(1'b0, 1'b0, 5);
    i_clr = 1'b1;
    @(posedge i_clk);
    #1 i_clr = 1'b0;
    chk("t6_abort_done", {31'd0, o_done}, 32'd0);
    chk("t6_abort_addr", o_im_addr, 32'h0);
    send_frame(1'b0, 1'b0, -1);
    chk("t6_done", {31'd0, o_done}, 32'd1);
    repeat (3) @(negedge i_clk);
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
